// File: rtl/caravel_scff_chain_if.sv
// Scan-chain control and data bundle for caravel_scff_chain.
// The slave modport is the chain itself; the master modport is whatever
// drives the scan pins (pad ring or testbench).
interface caravel_scff_chain_if;
    logic        Test_en;
    logic        IO_ISOL_N;
    logic        sc_head;
    logic        sc_tail;
    logic [12:0] shift_count;
    logic        scan_full;

    modport slave (
        input  Test_en,
        input  IO_ISOL_N,
        input  sc_head,
        output sc_tail,
        output shift_count,
        output scan_full
    );

    modport master (
        output Test_en,
        output IO_ISOL_N,
        output sc_head,
        input  sc_tail,
        input  shift_count,
        input  scan_full
    );
endinterface

// File: rtl/caravel_scff_chain.sv
// Serial scan flip-flop chain with a saturating shift counter.
//
// Pad assignment on the user I/O ring:
//   Test_en = io[0], IO_ISOL_N = io[1], Reset = io[2],
//   sc_head = io[26], op_clk = io[36], sc_tail = io[11]
//
// Data enters at chain[0] and leaves from chain[SCAN_SIZE-1]. The tail is
// gated by IO_ISOL_N without a register so isolation takes effect in the
// same cycle. Reset is synchronous and wins over Test_en.
module caravel_scff_chain #(
    parameter int SCAN_SIZE = 1024
) (
    input  logic                 op_clk,
    input  logic                 Reset,
    caravel_scff_chain_if.slave  scan_if
);

    localparam logic [12:0] CNT_MAX  = 13'h1FFF;
    localparam logic [12:0] FULL_LVL = 13'(SCAN_SIZE);

    logic [SCAN_SIZE-1:0] chain_q;
    logic [SCAN_SIZE-1:0] chain_d;
    logic [12:0]          cnt_q;
    logic [12:0]          cnt_d;

    // Next state: shift one place toward the tail and count, or hold.
    always_comb begin
        chain_d = chain_q;
        cnt_d   = cnt_q;
        if (scan_if.Test_en) begin
            chain_d = {chain_q[SCAN_SIZE-2:0], scan_if.sc_head};
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 13'd1;
            end
        end
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge op_clk) begin
        if (!Reset) begin
            chain_q <= '0;
            cnt_q   <= '0;
        end else begin
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
        end
    end

    assign scan_if.sc_tail     = chain_q[SCAN_SIZE-1] & scan_if.IO_ISOL_N;
    assign scan_if.shift_count = cnt_q;
    assign scan_if.scan_full   = (cnt_q >= FULL_LVL);

endmodule

// File: tb/tb_caravel_scff_chain.sv
// Testbench for caravel_scff_chain (SCAN_SIZE = 1024).
// The reference model keeps the last SCAN_SIZE shifted-in bits in a queue
// and a plain saturating integer count.
module tb_caravel_scff_chain;

    localparam int SCAN = 1024;

    logic op_clk = 1'b0;
    logic Reset  = 1'b1;

    caravel_scff_chain_if sif ();

    caravel_scff_chain #(.SCAN_SIZE(SCAN)) dut (
        .op_clk (op_clk),
        .Reset  (Reset),
        .scan_if(sif)
    );

    always #5 op_clk = ~op_clk;

    int n_checks = 0;
    int n_errors = 0;

    bit hist[$];
    int m_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_tail();
        if (hist.size() == SCAN) return hist[0] & sif.IO_ISOL_N;
        return 1'b0;
    endfunction

    task automatic check_model();
        check_val("tail", {31'd0, sif.sc_tail}, {31'd0, exp_tail()});
        check_val("count", {19'd0, sif.shift_count}, m_cnt);
        check_val("full", {31'd0, sif.scan_full}, (m_cnt >= SCAN) ? 1 : 0);
    endtask

    // One clock edge with the given inputs, then model update and compare.
    task automatic cyc(input logic rst_n, input logic en, input logic head);
        Reset       = rst_n;
        sif.Test_en = en;
        sif.sc_head = head;
        @(posedge op_clk);
        if (!rst_n) begin
            hist.delete();
            m_cnt = 0;
        end else if (en) begin
            hist.push_back(head);
            if (hist.size() > SCAN) void'(hist.pop_front());
            if (m_cnt < 8191) m_cnt++;
        end
        #1;
        check_model();
    endtask

    bit pat[SCAN];

    initial begin
        int n;
        bit found;
        sif.Test_en   = 1'b0;
        sif.IO_ISOL_N = 1'b1;
        sif.sc_head   = 1'b0;

        // Reset state, with Test_en also high to confirm reset priority.
        cyc(1'b0, 1'b1, 1'b1);
        check_val("rst_tail", {31'd0, sif.sc_tail}, 0);
        check_val("rst_count", {19'd0, sif.shift_count}, 0);
        check_val("rst_full", {31'd0, sif.scan_full}, 0);

        // Pulse: single 1 on the first shift edge.
        cyc(1'b1, 1'b1, 1'b1);
        for (int e = 2; e <= 1027; e++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (e == 1023) check_val("full_at_1023", {31'd0, sif.scan_full}, 0);
            if (e == 1024) begin
                check_val("pulse_1025", {31'd0, sif.sc_tail}, 1);
                check_val("full_at_1024", {31'd0, sif.scan_full}, 1);
            end
            if (e == 1025) check_val("pulse_1026", {31'd0, sif.sc_tail}, 0);
            if (e == 1026) check_val("pulse_1027", {31'd0, sif.sc_tail}, 0);
        end

        // Hold: one 1 in, 50 idle edges, then shift until it appears.
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 1'b0);
        check_val("hold_count", {19'd0, sif.shift_count}, 1);
        n = 0;
        found = 1'b0;
        while (!found && n < 2000) begin
            cyc(1'b1, 1'b1, 1'b0);
            n++;
            if (sif.sc_tail === 1'b1) found = 1'b1;
        end
        check_val("hold_latency", 1 + 50 + n, SCAN + 50);

        // Isolation: all-ones chain, gate toggled without a clock edge.
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SCAN; i++) cyc(1'b1, 1'b1, 1'b1);
        sif.IO_ISOL_N = 1'b0;
        #1;
        check_val("iso_off", {31'd0, sif.sc_tail}, 0);
        sif.IO_ISOL_N = 1'b1;
        #1;
        check_val("iso_on", {31'd0, sif.sc_tail}, 1);

        // Reset mid-shift: 512 ones, one reset edge, then zeros.
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 512; i++) cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        check_val("midrst_count", {19'd0, sif.shift_count}, 0);
        n = 0;
        for (int i = 0; i < SCAN; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (sif.sc_tail !== 1'b0) n++;
        end
        check_val("midrst_tail_ones", n, 0);

        // Counter saturation.
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9000; i++) cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        check_val("sat_count", {19'd0, sif.shift_count}, 8191);
        check_val("sat_full", {31'd0, sif.scan_full}, 1);

        // Round trip of a random pattern.
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SCAN; i++) begin
            pat[i] = 1'($urandom_range(0, 1));
            cyc(1'b1, 1'b1, pat[i]);
        end
        check_val("rt_bit0", {31'd0, sif.sc_tail}, {31'd0, pat[0]});
        n = 0;
        for (int i = 1; i < SCAN; i++) begin
            cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)));
            if (sif.sc_tail !== pat[i]) n++;
        end
        check_val("rt_mismatches", n, 0);

        // Random mix of shift, hold, isolation and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) sif.IO_ISOL_N = 1'($urandom_range(0, 1));
            cyc(($urandom_range(0, 299) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/caravel_scff_chain.md
CARAVEL_SCFF_CHAIN -- requirements
Module: caravel_scff_chain

Interface
REQ-001 SHALL have parameter SCAN_SIZE, default 1024, giving the number of scan flip-flops in the chain (legal range 2..4096).
REQ-002 SHALL use one clock and a synchronous, active-low reset, as listed in REQ-003 and REQ-004.
REQ-003 SHALL have port op_clk, input, 1 bit: operating and scan clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous active-low reset, sampled on rising op_clk.
REQ-005 SHALL have port Test_en, input, 1 bit: 1 = shift enabled, 0 = chain holds.
REQ-006 SHALL have port IO_ISOL_N, input, 1 bit: 0 = outputs isolated (forced 0), 1 = outputs driven from the chain.
REQ-007 SHALL have port sc_head, input, 1 bit: serial scan-in, loaded into flop 0.
REQ-008 SHALL have port sc_tail, output, 1 bit: serial scan-out, the value of flop SCAN_SIZE-1 gated by IO_ISOL_N.
REQ-009 SHALL have port shift_count, output, 13 bits: saturating count of shift cycles since reset.
REQ-010 SHALL have port scan_full, output, 1 bit: 1 once shift_count >= SCAN_SIZE.
REQ-011 SHALL map ports to the user I/O pads as follows: Test_en=io[0], IO_ISOL_N=io[1], Reset=io[2], sc_head=io[26], op_clk=io[36], sc_tail=io[11].

Function
REQ-012 SHALL implement chain[0..SCAN_SIZE-1] as D flip-flops clocked by op_clk.
REQ-013 SHALL, on a rising edge with Reset=1 and Test_en=1, perform chain[0]<=sc_head and chain[i]<=chain[i-1] for i=1..SCAN_SIZE-1.
REQ-014 SHALL, on a rising edge with Reset=1 and Test_en=0, leave all chain bits and shift_count unchanged.
REQ-015 SHALL define sc_tail = chain[SCAN_SIZE-1] AND IO_ISOL_N, combinationally with no extra register.
REQ-016 SHALL give latency as follows: a bit sampled on sc_head at shift edge k appears on sc_tail after shift edge k+SCAN_SIZE-1, so it is sampled by the next edge (edge k+SCAN_SIZE).
REQ-017 SHALL increment shift_count by 1 on each shift edge and saturate at 8191, with no wrap-around.
REQ-018 SHALL set scan_full = (shift_count >= SCAN_SIZE), combinationally.
REQ-019 SHALL give Reset=0 priority over Test_en when both are active on the same edge.
REQ-020 SHALL have no X-propagation paths: all outputs are defined from the first edge after reset.

Reset
REQ-021 SHALL, on a rising edge with Reset=0, clear all chain bits to 0 and clear shift_count to 0.
REQ-022 SHALL hold sc_tail=0 and scan_full=0 after reset until new data is shifted in.
REQ-023 SHALL, when Reset is asserted mid-shift, discard the partial contents on that same edge; shifting resumes from an empty chain on the first edge with Reset=1.
REQ-024 SHALL NOT reset asynchronously: reset requires at least one op_clk edge to take effect.

Verification
REQ-025 SHALL cover the pulse test: reset, then Test_en=1 and IO_ISOL_N=1, sc_head=1 for the first shift edge and 0 thereafter -> sc_tail sampled =1 at edge SCAN_SIZE+1 (1025) and =0 at edges 1026 and 1027.
REQ-026 SHALL cover hold: shift a single 1 in, then Test_en=0 for 50 edges -> chain unchanged and shift_count frozen; resume shifting -> the 1 reaches sc_tail 50 edges later than without the hold.
REQ-027 SHALL cover isolation: chain loaded all-ones with IO_ISOL_N=0 -> sc_tail=0; IO_ISOL_N=1 -> sc_tail=1 in the same cycle.
REQ-028 SHALL cover reset mid-shift: shift 512 ones, then Reset=0 for one edge -> shift_count=0 and SCAN_SIZE further zero-shifts give sc_tail=0 throughout.
REQ-029 SHALL cover counter boundaries: shift_count=1023 -> scan_full=0; shift_count=1024 -> scan_full=1; after 9000 shifts -> shift_count=8191.
REQ-030 SHALL cover a pattern round-trip: shift 1024 random bits -> the same sequence emerges on sc_tail, in order, over the next 1024 edges.
